regbank_stim_gen: RTL and testbench

- Sequenced stimulus generator that drives the register bank under test and its checker in Banco A.
- Produces write and dual-read port traffic in phases: deterministic fill, deterministic read-back, then an optional pseudo-random mixed phase.
- Every output is registered, so the bank and the checker both sample the same stable operation on each clock edge.
- Reports progress through `busy`, a one-cycle `done` pulse and an operation counter.

---
 rtl/regbank_stim_gen.sv | 231 +++++++++++++++++++++++
 tb/tb_regbank_stim_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/regbank_stim_gen.sv
// regbank_stim_gen: phased stimulus generator for a register bank and its checker.
// Sequence: FILL (write 0xA500+i to every register), READ (dual-port read-back
// with mirrored addresses), optional pseudo-random mixed phase, then a DONE pulse.
// Optional feature: define REGBANK_STIM_RAND_EN to build the RAND phase and LFSR.
// Every output is a register so the bank and the checker see the same operation.
module regbank_stim_gen #(
  parameter int          NUM_REGS = 14,
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 4,
  parameter int          RAND_OPS = 32,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              we,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0] addr_rd1,
  output logic [ADDR_W-1:0] addr_rd2,
  output logic [15:0]       op_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  // Parameter sanity: every index must fit the address field, and a zero seed
  // would lock the LFSR.
  if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
    $error("regbank_stim_gen: NUM_REGS does not fit ADDR_W");
  end
  if (RAND_OPS < 1 || SEED == 16'h0000) begin : g_bad_rand_cfg
    $error("regbank_stim_gen: RAND_OPS must be positive and SEED non-zero");
  end

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_READ, S_RAND, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] idx_reg, idx_next;
  logic [15:0]       op_count_reg, op_count_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              we_reg, we_next;
  logic [ADDR_W-1:0] addr_wr_reg, addr_wr_next;
  logic [DATA_W-1:0] data_in_reg, data_in_next;
  logic [ADDR_W-1:0] addr_rd1_reg, addr_rd1_next;
  logic [ADDR_W-1:0] addr_rd2_reg, addr_rd2_next;
  logic              active;

`ifdef REGBANK_STIM_RAND_EN
  localparam int RC_W = (RAND_OPS > 1) ? $clog2(RAND_OPS) : 1;
  localparam logic [RC_W-1:0] LAST_RAND = RC_W'(RAND_OPS - 1);

  logic [15:0]     lfsr_reg, lfsr_next;
  logic [RC_W-1:0] rand_cnt_reg, rand_cnt_next;

  // Galois right-shift step, feedback mask 0xB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // Map a 4-bit field onto a legal register address.
  function automatic logic [ADDR_W-1:0] fold(input logic [3:0] a);
    if (int'(a) >= NUM_REGS) return ADDR_W'(int'(a) - NUM_REGS);
    return ADDR_W'(a);
  endfunction
`endif

  assign active = (state_reg == S_FILL) || (state_reg == S_READ) || (state_reg == S_RAND);

  // Next-state, counters and the operation to register for the next cycle.
  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    op_count_next = op_count_reg;
`ifdef REGBANK_STIM_RAND_EN
    lfsr_next     = lfsr_reg;
    rand_cnt_next = rand_cnt_reg;
`endif
    busy_next     = 1'b0;
    done_next     = 1'b0;
    we_next       = 1'b0;
    addr_wr_next  = '0;
    data_in_next  = '0;
    addr_rd1_next = '0;
    addr_rd2_next = '0;

    // An operation that advances has been presented for a full cycle: count it.
    if (active && !hold) begin
      op_count_next = (op_count_reg == 16'hFFFF) ? op_count_reg : op_count_reg + 16'd1;
    end

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next    = S_FILL;
          idx_next      = '0;
          op_count_next = 16'd0;
`ifdef REGBANK_STIM_RAND_EN
          lfsr_next     = SEED;
`endif
        end
      end
      S_FILL: begin
        if (!hold) begin
          if (idx_reg == LAST_IDX) begin
            state_next = S_READ;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
      S_READ: begin
        if (!hold) begin
          if (idx_reg == LAST_IDX) begin
            idx_next = '0;
`ifdef REGBANK_STIM_RAND_EN
            state_next    = S_RAND;
            rand_cnt_next = '0;
            lfsr_next     = lfsr_step(lfsr_reg);
`else
            state_next = S_DONE;
`endif
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end
`ifdef REGBANK_STIM_RAND_EN
      S_RAND: begin
        if (!hold) begin
          if (rand_cnt_reg == LAST_RAND) begin
            state_next = S_DONE;
          end else begin
            rand_cnt_next = rand_cnt_reg + 1'b1;
            lfsr_next     = lfsr_step(lfsr_reg);
          end
        end
      end
`endif
      S_DONE: begin
        state_next    = S_IDLE;
        op_count_next = 16'd0;
      end
      default: state_next = S_IDLE;
    endcase

    // A held cycle is a bubble: no write, addresses and data parked.
    if (active && hold) begin
      busy_next     = 1'b1;
      addr_wr_next  = addr_wr_reg;
      data_in_next  = data_in_reg;
      addr_rd1_next = addr_rd1_reg;
      addr_rd2_next = addr_rd2_reg;
    end else begin
      case (state_next)
        S_FILL: begin
          busy_next    = 1'b1;
          we_next      = 1'b1;
          addr_wr_next = idx_next;
          data_in_next = DATA_W'(16'hA500) + DATA_W'(idx_next);
        end
        S_READ: begin
          busy_next     = 1'b1;
          addr_rd1_next = idx_next;
          addr_rd2_next = LAST_IDX - idx_next;
        end
`ifdef REGBANK_STIM_RAND_EN
        S_RAND: begin
          busy_next     = 1'b1;
          we_next       = lfsr_next[0];
          data_in_next  = DATA_W'(lfsr_next);
          addr_wr_next  = fold(lfsr_next[7:4]);
          addr_rd1_next = fold(lfsr_next[11:8]);
          addr_rd2_next = fold(lfsr_next[15:12]);
        end
`endif
        S_DONE:  done_next = 1'b1;
        default: ;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      op_count_reg <= 16'd0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      we_reg       <= 1'b0;
      addr_wr_reg  <= '0;
      data_in_reg  <= '0;
      addr_rd1_reg <= '0;
      addr_rd2_reg <= '0;
`ifdef REGBANK_STIM_RAND_EN
      lfsr_reg     <= SEED;
      rand_cnt_reg <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      op_count_reg <= op_count_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      we_reg       <= we_next;
      addr_wr_reg  <= addr_wr_next;
      data_in_reg  <= data_in_next;
      addr_rd1_reg <= addr_rd1_next;
      addr_rd2_reg <= addr_rd2_next;
`ifdef REGBANK_STIM_RAND_EN
      lfsr_reg     <= lfsr_next;
      rand_cnt_reg <= rand_cnt_next;
`endif
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign we       = we_reg;
  assign addr_wr  = addr_wr_reg;
  assign data_in  = data_in_reg;
  assign addr_rd1 = addr_rd1_reg;
  assign addr_rd2 = addr_rd2_reg;
  assign op_count = op_count_reg;

endmodule

// File: tb/tb_regbank_stim_gen.sv
// tb_regbank_stim_gen: randomized bench for regbank_stim_gen. The reference is an
// ordered list of the operations one run must present, plus a cursor that steps
// through it (or shows a bubble when held).
module tb_regbank_stim_gen;

  localparam int          NUM_REGS = 14;
  localparam int          DATA_W   = 16;
  localparam int          ADDR_W   = 4;
  localparam int          RAND_OPS = 32;
  localparam logic [15:0] SEED     = 16'hACE1;
`ifdef REGBANK_STIM_RAND_EN
  localparam int RUN_LEN = 2 * NUM_REGS + RAND_OPS;
`else
  localparam int RUN_LEN = 2 * NUM_REGS;
`endif

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        we;
    logic [3:0]  aw;
    logic [15:0] din;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [15:0] cnt;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst, start, hold;
  logic              busy, done, we;
  logic [ADDR_W-1:0] addr_wr, addr_rd1, addr_rd2;
  logic [DATA_W-1:0] data_in;
  logic [15:0]       op_count;

  regbank_stim_gen #(
    .NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W),
    .RAND_OPS(RAND_OPS), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .we(we),
    .addr_wr(addr_wr), .data_in(data_in),
    .addr_rd1(addr_rd1), .addr_rd2(addr_rd2),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  obs_t  ideal [RUN_LEN];
  obs_t  exp_o;
  int    pos;
  string cur_tag;
  int    busy_seen, done_seen, bad_addr, hold_active, final_cnt, first_rand;
  bit    rand_seen;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  function automatic logic [15:0] lfsr_next_val(input logic [15:0] v);
    logic lsb;
    lsb = v[0];
    v   = v >> 1;
    if (lsb) v = v ^ 16'hB400;
    return v;
  endfunction

  function automatic logic [3:0] fold(input logic [3:0] a);
    return (a >= NUM_REGS) ? a - 4'(NUM_REGS) : a;
  endfunction

  // The complete operation list of one uninterrupted run.
  task automatic build_ideal();
    logic [15:0] l;
    for (int i = 0; i < NUM_REGS; i++) begin
      ideal[i] = '{busy: 1'b1, done: 1'b0, we: 1'b1, aw: 4'(i), din: 16'hA500 + 16'(i),
                   r1: 4'd0, r2: 4'd0, cnt: 16'(i)};
      ideal[NUM_REGS + i] = '{busy: 1'b1, done: 1'b0, we: 1'b0, aw: 4'd0, din: 16'd0,
                              r1: 4'(i), r2: 4'(NUM_REGS - 1 - i), cnt: 16'(NUM_REGS + i)};
    end
    l = SEED;
    for (int j = 2 * NUM_REGS; j < RUN_LEN; j++) begin
      l = lfsr_next_val(l);
      ideal[j] = '{busy: 1'b1, done: 1'b0, we: l[0], aw: fold(l[7:4]), din: l,
                   r1: fold(l[11:8]), r2: fold(l[15:12]), cnt: 16'(j)};
    end
  endtask

  task automatic clear_stats();
    busy_seen = 0; done_seen = 0; bad_addr = 0; hold_active = 0;
    final_cnt = -1; first_rand = -1; rand_seen = 0;
  endtask

  // Apply one cycle of inputs, advance the reference, then compare after the edge.
  task automatic step(input logic s, input logic h, input logic r);
    obs_t o;
    start = s; hold = h; rst = r;
    if (r) begin
      pos = -1; exp_o = '0;
    end else if (pos < 0) begin
      if (s) begin pos = 0; exp_o = ideal[0]; end
      else exp_o = '0;
    end else if (pos < RUN_LEN) begin
      if (h) begin
        exp_o.we = 1'b0;
        hold_active++;
      end else begin
        pos++;
        if (pos == RUN_LEN) begin
          exp_o = '0; exp_o.done = 1'b1; exp_o.cnt = 16'(RUN_LEN);
        end else begin
          exp_o = ideal[pos];
        end
      end
    end else begin
      pos = -1; exp_o = '0;
    end
    @(posedge clk);
    @(negedge clk);
    o = '{busy: busy, done: done, we: we, aw: addr_wr, din: data_in,
          r1: addr_rd1, r2: addr_rd2, cnt: op_count};
    check_val(cur_tag, 64'(o), 64'(exp_o));
    if (busy) busy_seen++;
    if (done) begin done_seen++; final_cnt = int'(op_count); end
    if (addr_wr > 4'd13 || addr_rd1 > 4'd13 || addr_rd2 > 4'd13) bad_addr++;
    if (pos == 2 * NUM_REGS && !rand_seen) begin rand_seen = 1; first_rand = int'(data_in); end
  endtask

  // Run from IDLE until the reference returns to IDLE; hold/start randomized per mode.
  task automatic run_to_idle(input int hold_pct, input bit stray_start);
    int guard = 0;
    while (pos != -1 && guard < 400) begin
      step(stray_start ? 1'($urandom_range(0, 1)) : 1'b0,
           1'($urandom_range(0, 99) < hold_pct), 1'b0);
      guard++;
    end
    check_val({cur_tag, "_terminated"}, 64'(pos), 64'(-1));
  endtask

  task automatic run_checks(input int extra_hold);
    check_val({cur_tag, "_busy_len"}, 64'(busy_seen), 64'(RUN_LEN + extra_hold));
    check_val({cur_tag, "_done_pulses"}, 64'(done_seen), 64'd1);
    check_val({cur_tag, "_final_count"}, 64'(final_cnt), 64'(RUN_LEN));
    check_val({cur_tag, "_addr_legal"}, 64'(bad_addr), 64'd0);
  endtask

  initial begin
    int left;
    build_ideal();
    pos = -1; exp_o = '0;
    clear_stats();

    cur_tag = "reset";
    repeat (3) step(1'b0, 1'b0, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0);   // first of these starts a run
    run_to_idle(0, 1'b0);

    cur_tag = "fill_read";
    clear_stats();
    step(1'b1, 1'b0, 1'b0);
    run_to_idle(0, 1'b0);
    run_checks(0);
`ifdef REGBANK_STIM_RAND_EN
    check_val("first_rand_data", 64'(first_rand), 64'h0000_E270);
`endif

    cur_tag = "hold";
    clear_stats();
    step(1'b1, 1'b0, 1'b0);
    left = 4;
    for (int g = 0; g < 400 && pos != -1; g++) begin
      if (pos == 3 && left > 0) begin step(1'b0, 1'b1, 1'b0); left--; end
      else step(1'b0, 1'b0, 1'b0);
    end
    run_checks(4);

    cur_tag = "start_mask";
    clear_stats();
    for (int g = 0; g < 400 && done_seen < 2; g++) step(1'b1, 1'b0, 1'b0);
    run_to_idle(0, 1'b0);
    check_val("start_mask_busy", 64'(busy_seen), 64'(2 * RUN_LEN));
    check_val("start_mask_done", 64'(done_seen), 64'd2);

    cur_tag = "reset_mid";
    clear_stats();
    step(1'b1, 1'b0, 1'b0);
    for (int g = 0; g < 20 && pos < 5; g++) step(1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check_val("reset_mid_no_done", 64'(done_seen), 64'd0);
    cur_tag = "restart";
    clear_stats();
    step(1'b1, 1'b0, 1'b0);
    run_to_idle(0, 1'b0);
    run_checks(0);

    for (int r = 0; r < 6; r++) begin
      cur_tag = $sformatf("random%0d", r);
      clear_stats();
      repeat ($urandom_range(0, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      run_to_idle(25, 1'b1);
      run_checks(hold_active);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
